// File: rtl/ad9361_spi_arb_pkg.sv
// Shared constants and types for the two-port AD9361 SPI register-access arbiter.
package ad9361_spi_arb_pkg;
  localparam int ADDR_W       = 10;
  localparam int DATA_W       = 8;
  localparam int NUM_PORTS    = 2;
  localparam int CNT_W        = 16;
  localparam int TO_ISSUE_DEF = 1024;
  localparam int TO_XFER_DEF  = 65535;

  typedef enum logic [4:0] {
    ST_IDLE      = 5'b00001,
    ST_ISSUE     = 5'b00010,
    ST_WAIT_BUSY = 5'b00100,
    ST_WAIT_DONE = 5'b01000,
    ST_RESP      = 5'b10000
  } state_e;

  typedef struct packed {
    logic              wr_rd;
    logic [ADDR_W-1:0] addr;
    logic [DATA_W-1:0] wdata;
  } cmd_t;
endpackage

// File: rtl/ad9361_spi_arb.sv
// Round-robin arbiter letting two requesters share one AD9361 SPI register driver.
// Optional watchdog on issue/transfer phases enabled by defining SPI_ARB_TIMEOUT_EN.
module ad9361_spi_arb
  import ad9361_spi_arb_pkg::*;
#(
  parameter int TO_ISSUE = TO_ISSUE_DEF,
  parameter int TO_XFER  = TO_XFER_DEF
) (
  input  logic              sys_clk,
  input  logic              sys_rst,
  input  logic              req0,
  input  logic              wr_rd0,
  input  logic [ADDR_W-1:0] addr0,
  input  logic [DATA_W-1:0] wdata0,
  output logic              ack0,
  output logic              done0,
  output logic [DATA_W-1:0] rdata0,
  output logic              err0,
  input  logic              req1,
  input  logic              wr_rd1,
  input  logic [ADDR_W-1:0] addr1,
  input  logic [DATA_W-1:0] wdata1,
  output logic              ack1,
  output logic              done1,
  output logic [DATA_W-1:0] rdata1,
  output logic              err1,
  output logic [ADDR_W-1:0] ad9361_reg_addr,
  output logic [DATA_W-1:0] ad9361_reg_data_in,
  output logic              ad9361_reg_data_in_en,
  output logic              ad9361_reg_wr_rdn,
  input  logic [DATA_W-1:0] ad9361_reg_data_out,
  input  logic              ad9361_reg_data_out_en,
  input  logic              ad9361_spi_busy,
  output logic              arb_owner
);

  logic [NUM_PORTS-1:0]             req;
  cmd_t [NUM_PORTS-1:0]             rq;

  state_e                           state_q, state_d;
  logic                             owner_q, owner_d;
  logic                             favour_q, favour_d;
  cmd_t                             cmd_q, cmd_d;
  logic                             en_q, en_d;
  logic [NUM_PORTS-1:0]             ack_q, ack_d;
  logic [NUM_PORTS-1:0]             done_q, done_d;
  logic [NUM_PORTS-1:0][DATA_W-1:0] rdata_q, rdata_d;
  logic                             win;
  logic                             issue_to, xfer_to;

  assign req   = {req1, req0};
  assign rq[0] = '{wr_rd: wr_rd0, addr: addr0, wdata: wdata0};
  assign rq[1] = '{wr_rd: wr_rd1, addr: addr1, wdata: wdata1};

`ifdef SPI_ARB_TIMEOUT_EN
  logic [CNT_W-1:0]     cnt_q, cnt_d;
  logic                 to_q, to_d;
  logic [NUM_PORTS-1:0] err_q, err_d;

  assign issue_to = (cnt_q == CNT_W'(TO_ISSUE - 1));
  assign xfer_to  = (cnt_q == CNT_W'(TO_XFER - 1));
  assign err0     = err_q[0];
  assign err1     = err_q[1];
`else
  logic unused_to;

  assign issue_to  = 1'b0;
  assign xfer_to   = 1'b0;
  assign err0      = 1'b0;
  assign err1      = 1'b0;
  assign unused_to = ^{TO_ISSUE, TO_XFER};
`endif

  always_comb begin
    state_d  = state_q;
    owner_d  = owner_q;
    favour_d = favour_q;
    cmd_d    = cmd_q;
    en_d     = en_q;
    ack_d    = '0;
    done_d   = '0;
    rdata_d  = rdata_q;
    win      = 1'b0;
`ifdef SPI_ARB_TIMEOUT_EN
    to_d     = to_q;
    err_d    = '0;
`endif
    case (state_q)
      ST_IDLE: begin
        if (!ad9361_spi_busy && (|req)) begin
          // The favour pointer only moves when a tie is actually resolved.
          if (&req) begin
            win      = favour_q;
            favour_d = ~favour_q;
          end else begin
            win = req[1];
          end
          owner_d    = win;
          cmd_d      = rq[win];
          ack_d[win] = 1'b1;
          state_d    = ST_ISSUE;
`ifdef SPI_ARB_TIMEOUT_EN
          to_d       = 1'b0;
`endif
        end
      end
      ST_ISSUE: begin
        en_d    = 1'b1;
        state_d = ST_WAIT_BUSY;
      end
      ST_WAIT_BUSY: begin
        if (ad9361_spi_busy) begin
          en_d    = 1'b0;
          state_d = ST_WAIT_DONE;
        end else if (issue_to) begin
          en_d    = 1'b0;
          state_d = ST_RESP;
`ifdef SPI_ARB_TIMEOUT_EN
          to_d    = 1'b1;
`endif
        end
      end
      ST_WAIT_DONE: begin
        // Reads finish only on the data strobe, even if busy has already fallen.
        if (cmd_q.wr_rd ? !ad9361_spi_busy : ad9361_reg_data_out_en) begin
          if (!cmd_q.wr_rd) rdata_d[owner_q] = ad9361_reg_data_out;
          state_d = ST_RESP;
        end else if (xfer_to) begin
          state_d = ST_RESP;
`ifdef SPI_ARB_TIMEOUT_EN
          to_d    = 1'b1;
`endif
        end
      end
      ST_RESP: begin
        done_d[owner_q] = 1'b1;
`ifdef SPI_ARB_TIMEOUT_EN
        err_d[owner_q]  = to_q;
`endif
        state_d         = ST_IDLE;
      end
      default: state_d = ST_IDLE;
    endcase
  end

`ifdef SPI_ARB_TIMEOUT_EN
  always_comb begin
    cnt_d = cnt_q + 16'd1;
    if (state_d != state_q || state_q == ST_IDLE) cnt_d = '0;
  end

  always_ff @(posedge sys_clk or posedge sys_rst) begin
    if (sys_rst) begin
      cnt_q <= '0;
      to_q  <= 1'b0;
      err_q <= '0;
    end else begin
      cnt_q <= cnt_d;
      to_q  <= to_d;
      err_q <= err_d;
    end
  end
`endif

  always_ff @(posedge sys_clk or posedge sys_rst) begin
    if (sys_rst) begin
      state_q  <= ST_IDLE;
      owner_q  <= 1'b0;
      favour_q <= 1'b0;
      cmd_q    <= '0;
      en_q     <= 1'b0;
      ack_q    <= '0;
      done_q   <= '0;
      rdata_q  <= '0;
    end else begin
      state_q  <= state_d;
      owner_q  <= owner_d;
      favour_q <= favour_d;
      cmd_q    <= cmd_d;
      en_q     <= en_d;
      ack_q    <= ack_d;
      done_q   <= done_d;
      rdata_q  <= rdata_d;
    end
  end

  assign ack0                  = ack_q[0];
  assign ack1                  = ack_q[1];
  assign done0                 = done_q[0];
  assign done1                 = done_q[1];
  assign rdata0                = rdata_q[0];
  assign rdata1                = rdata_q[1];
  assign ad9361_reg_addr       = cmd_q.addr;
  assign ad9361_reg_data_in    = cmd_q.wdata;
  assign ad9361_reg_wr_rdn     = cmd_q.wr_rd;
  assign ad9361_reg_data_in_en = en_q;
  assign arb_owner             = owner_q;

endmodule
